// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage controller of the LEGv8 pipeline.
// Provides the access-FSM state encoding and default widths.
package mem_stage_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_REG_W   = 5;
  localparam int DEF_TIMEOUT = 255;

  // IDLE     : ready to accept the instruction leaving EX/MEM
  // REQ      : data-memory request presented, waiting for ready
  // WAIT_RSP : load request accepted, waiting for read data
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access watchdog for the MEM stage.
// Counts cycles while en_i is high; clr_i has priority and zeroes the count.
// expired_o is high in the cycle that would be the TIMEOUT-th counted cycle,
// so the owner can abort on that same edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear count
//   en_i       : count this cycle
//   expired_o  : this enabled cycle is the TIMEOUT-th one
module mem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: consumer end of the EX/MEM pipeline register.
// Resolves branches combinationally, runs data-memory accesses over a
// valid/ready request + valid response handshake, stalls upstream while an
// access is outstanding, and delivers registered WB fields toward MEM/WB.
//   ex_valid, isZeroBranch, isUnconBranch, memRead, memwrite, regwrite,
//   mem2reg, shifted_PC, alu_zero, alu_result, write_data_mem, write_reg
//                         : fields leaving EX/MEM
//   dm_req_* / dm_rsp_*   : data-memory request / response channels
//   stall                 : hold IF/ID/EX and EX/MEM
//   pc_src, branch_target, flush : branch redirect
//   wb_*                  : registered WB-stage fields, wb_valid is a 1-cycle pulse
//   mem_timeout           : sticky flag, an access was aborted by the watchdog
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              isZeroBranch,
  input  logic              isUnconBranch,
  input  logic              memRead,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic              mem2reg,
  input  logic [DATA_W-1:0] shifted_PC,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data_mem,
  input  logic [REG_W-1:0]  write_reg,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_we,
  output logic [DATA_W-1:0] dm_req_addr,
  output logic [DATA_W-1:0] dm_req_wdata,
  input  logic              dm_rsp_valid,
  input  logic [DATA_W-1:0] dm_rsp_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_mem2reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              mem_timeout
);

  state_e              state_q;
  logic                req_valid_q, req_we_q;
  logic [DATA_W-1:0]   req_addr_q, req_wdata_q;
  // WB fields of the in-flight memory op, released on completion
  logic                pend_regwrite_q, pend_mem2reg_q;
  logic [REG_W-1:0]    pend_write_reg_q;
  logic                wb_valid_q, wb_regwrite_q, wb_mem2reg_q;
  logic [DATA_W-1:0]   wb_read_data_q, wb_alu_result_q;
  logic [REG_W-1:0]    wb_write_reg_q;
  logic                mem_timeout_q;

  logic                accept, is_mem;
  logic                fin, go_wait, abort, expired;
  logic [DATA_W-1:0]   fin_rdata;

  assign accept = ex_valid && (state_q == IDLE);
  assign is_mem = memRead || memwrite;

  // Branch resolution is independent of any memory flags on the same op
  assign pc_src        = accept && (isUnconBranch || (isZeroBranch && alu_zero));
  assign flush         = pc_src;
  assign branch_target = shifted_PC;

  assign stall = (state_q != IDLE) || (accept && is_mem);

  // Completion decode for the access in flight
  always_comb begin
    fin       = 1'b0;
    go_wait   = 1'b0;
    fin_rdata = '0;
    case (state_q)
      REQ: begin
        if (dm_req_ready) begin
          if (req_we_q) begin
            fin = 1'b1;
          end else if (dm_rsp_valid) begin
            fin       = 1'b1;
            fin_rdata = dm_rsp_rdata;
          end else begin
            go_wait = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        if (dm_rsp_valid) begin
          fin       = 1'b1;
          fin_rdata = dm_rsp_rdata;
        end
      end
      default: ;
    endcase
  end

  // A completion on the expiry edge wins over the abort
  assign abort = expired && !fin;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q == IDLE) || fin || abort),
    .en_i      (state_q != IDLE),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      req_valid_q      <= 1'b0;
      req_we_q         <= 1'b0;
      req_addr_q       <= '0;
      req_wdata_q      <= '0;
      pend_regwrite_q  <= 1'b0;
      pend_mem2reg_q   <= 1'b0;
      pend_write_reg_q <= '0;
      wb_valid_q       <= 1'b0;
      wb_regwrite_q    <= 1'b0;
      wb_mem2reg_q     <= 1'b0;
      wb_read_data_q   <= '0;
      wb_alu_result_q  <= '0;
      wb_write_reg_q   <= '0;
      mem_timeout_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_mem) begin
            state_q          <= REQ;
            req_valid_q      <= 1'b1;
            req_we_q         <= memwrite;
            req_addr_q       <= alu_result;
            req_wdata_q      <= write_data_mem;
            pend_regwrite_q  <= regwrite;
            pend_mem2reg_q   <= mem2reg;
            pend_write_reg_q <= write_reg;
          end else if (accept) begin
            wb_valid_q      <= 1'b1;
            wb_regwrite_q   <= regwrite;
            wb_mem2reg_q    <= mem2reg;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= alu_result;
            wb_write_reg_q  <= write_reg;
          end
        end
        REQ: begin
          if (fin || abort) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end else if (go_wait) begin
            state_q     <= WAIT_RSP;
            req_valid_q <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (fin || abort) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Retire the memory op; an aborted access must not write the register file
      if (fin || abort) begin
        wb_valid_q      <= 1'b1;
        wb_regwrite_q   <= pend_regwrite_q && !abort;
        wb_mem2reg_q    <= pend_mem2reg_q;
        wb_read_data_q  <= fin_rdata;
        wb_alu_result_q <= req_addr_q;
        wb_write_reg_q  <= pend_write_reg_q;
      end
      if (abort) mem_timeout_q <= 1'b1;
    end
  end

  assign dm_req_valid  = req_valid_q;
  assign dm_req_we     = req_we_q;
  assign dm_req_addr   = req_addr_q;
  assign dm_req_wdata  = req_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_mem2reg    = wb_mem2reg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, isZeroBranch, isUnconBranch, memRead, memwrite;
  logic          regwrite, mem2reg, alu_zero;
  logic [DW-1:0] shifted_PC, alu_result, write_data_mem;
  logic [RW-1:0] write_reg;
  logic          dm_req_valid, dm_req_ready, dm_req_we;
  logic [DW-1:0] dm_req_addr, dm_req_wdata;
  logic          dm_rsp_valid;
  logic [DW-1:0] dm_rsp_rdata;
  logic          stall, pc_src, flush;
  logic [DW-1:0] branch_target;
  logic          wb_valid, wb_regwrite, wb_mem2reg;
  logic [DW-1:0] wb_read_data, wb_alu_result;
  logic [RW-1:0] wb_write_reg;
  logic          mem_timeout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .isZeroBranch(isZeroBranch),
    .isUnconBranch(isUnconBranch), .memRead(memRead), .memwrite(memwrite),
    .regwrite(regwrite), .mem2reg(mem2reg), .shifted_PC(shifted_PC),
    .alu_zero(alu_zero), .alu_result(alu_result), .write_data_mem(write_data_mem),
    .write_reg(write_reg), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata), .stall(stall),
    .pc_src(pc_src), .branch_target(branch_target), .flush(flush),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_mem2reg(wb_mem2reg),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_write_reg(wb_write_reg), .mem_timeout(mem_timeout)
  );

  typedef struct {
    logic          ex_valid;
    logic          is_zero;
    logic          is_uncon;
    logic          alu_zero;
    logic          regwrite;
    logic [DW-1:0] pc;
    logic [DW-1:0] alu;
    logic [RW-1:0] wreg;
    logic          exp_pc_src;
    logic          exp_wb_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; isZeroBranch = 0; isUnconBranch = 0; memRead = 0; memwrite = 0;
    regwrite = 0; mem2reg = 0; alu_zero = 0; shifted_PC = '0; alu_result = '0;
    write_data_mem = '0; write_reg = '0; dm_req_ready = 0; dm_rsp_valid = 0;
    dm_rsp_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [DW-1:0] addr, input logic [RW-1:0] rd);
    ex_valid = 1; memRead = 1; mem2reg = 1; regwrite = 1; alu_result = addr; write_reg = rd;
    #1;
    chk("load_accept_stall", stall, 1);
    tick();
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,  64'h10, 5'd3, 1'b0, 1'b1}; // ADD
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h40, 64'h0,  5'd0, 1'b1, 1'b1}; // CBZ taken
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40, 64'h5,  5'd0, 1'b0, 1'b1}; // CBZ not taken
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h80, 64'h7,  5'd0, 1'b1, 1'b1}; // B
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h90, 64'h9,  5'd4, 1'b0, 1'b0}; // bubble
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA0, 64'h22, 5'd9, 1'b0, 1'b1}; // zero flag, no branch

    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_req_valid", dm_req_valid, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    rst_n = 1;
    tick();

    // Non-memory ops and branches, back to back
    for (int i = 0; i < 6; i++) begin
      ex_valid = vecs[i].ex_valid; isZeroBranch = vecs[i].is_zero;
      isUnconBranch = vecs[i].is_uncon; alu_zero = vecs[i].alu_zero;
      regwrite = vecs[i].regwrite; shifted_PC = vecs[i].pc;
      alu_result = vecs[i].alu; write_reg = vecs[i].wreg;
      #1;
      chk($sformatf("v%0d_pc_src", i), pc_src, vecs[i].exp_pc_src);
      chk($sformatf("v%0d_flush", i), flush, vecs[i].exp_pc_src);
      chk($sformatf("v%0d_target", i), branch_target, vecs[i].pc);
      chk($sformatf("v%0d_stall", i), stall, 0);
      tick();
      chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].exp_wb_valid);
      if (vecs[i].exp_wb_valid) begin
        chk($sformatf("v%0d_wb_alu", i), wb_alu_result, vecs[i].alu);
        chk($sformatf("v%0d_wb_reg", i), wb_write_reg, vecs[i].wreg);
        chk($sformatf("v%0d_wb_rw", i), wb_regwrite, vecs[i].regwrite);
        chk($sformatf("v%0d_wb_rdata", i), wb_read_data, 0);
      end
      chk($sformatf("v%0d_stall_after", i), stall, 0);
    end
    idle_inputs();
    tick();
    chk("idle_wb_valid", wb_valid, 0);

    // Response in IDLE is ignored
    dm_rsp_valid = 1; dm_rsp_rdata = 64'hBAD;
    tick();
    chk("idle_rsp_ignored", wb_valid, 0);
    idle_inputs();

    // STUR, ready low for 3 cycles; an ex_valid branch mid-access is ignored
    ex_valid = 1; memwrite = 1; alu_result = 64'h8; write_data_mem = 64'hDEAD;
    #1;
    chk("st_accept_stall", stall, 1);
    chk("st_accept_req_valid", dm_req_valid, 0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      dm_req_ready = (i == 3);
      if (i == 1) begin ex_valid = 1; isUnconBranch = 1; alu_result = 64'h77; end
      #1;
      chk($sformatf("st_c%0d_valid", i), dm_req_valid, 1);
      chk($sformatf("st_c%0d_addr", i), dm_req_addr, 64'h8);
      chk($sformatf("st_c%0d_wdata", i), dm_req_wdata, 64'hDEAD);
      chk($sformatf("st_c%0d_we", i), dm_req_we, 1);
      chk($sformatf("st_c%0d_stall", i), stall, 1);
      chk($sformatf("st_c%0d_pc_src", i), pc_src, 0);
      chk($sformatf("st_c%0d_wb_valid", i), wb_valid, 0);
      tick();
      idle_inputs();
    end
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_alu", wb_alu_result, 64'h8);
    chk("st_stall_drop", stall, 0);
    chk("st_req_drop", dm_req_valid, 0);
    tick();
    chk("st_wb_pulse_end", wb_valid, 0);

    // LDUR, ready immediately, response two cycles later
    start_load(64'h20, 5'd7);
    dm_req_ready = 1;
    #1;
    chk("ld_req_valid", dm_req_valid, 1);
    chk("ld_req_we", dm_req_we, 0);
    chk("ld_req_addr", dm_req_addr, 64'h20);
    tick();
    dm_req_ready = 0;
    chk("ld_wait_req_low", dm_req_valid, 0);
    chk("ld_wait_stall", stall, 1);
    tick();
    dm_rsp_valid = 1; dm_rsp_rdata = 64'h1234;
    chk("ld_wait2_wb_valid", wb_valid, 0);
    tick();
    idle_inputs();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_rdata", wb_read_data, 64'h1234);
    chk("ld_wb_mem2reg", wb_mem2reg, 1);
    chk("ld_wb_reg", wb_write_reg, 7);
    chk("ld_wb_rw", wb_regwrite, 1);
    chk("ld_stall_drop", stall, 0);
    tick();
    chk("ld_wb_pulse_end", wb_valid, 0);

    // LDUR with same-cycle ready and response
    start_load(64'h30, 5'd2);
    dm_req_ready = 1; dm_rsp_valid = 1; dm_rsp_rdata = 64'h55;
    tick();
    idle_inputs();
    chk("ldf_wb_valid", wb_valid, 1);
    chk("ldf_wb_rdata", wb_read_data, 64'h55);

    // Load with ready never high: abort after TO cycles
    start_load(64'h40, 5'd5);
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("to_c%0d_flag", i), mem_timeout, 0);
      chk($sformatf("to_c%0d_stall", i), stall, 1);
      tick();
    end
    chk("to_flag", mem_timeout, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_regwrite, 0);
    chk("to_req_valid", dm_req_valid, 0);
    chk("to_stall", stall, 0);
    ex_valid = 1; regwrite = 1; alu_result = 64'h99; write_reg = 5'd11;
    tick();
    idle_inputs();
    chk("to_add_wb_valid", wb_valid, 1);
    chk("to_add_wb_alu", wb_alu_result, 64'h99);
    chk("to_add_wb_rw", wb_regwrite, 1);
    chk("to_sticky", mem_timeout, 1);

    // Reset while waiting for a load response
    start_load(64'h50, 5'd6);
    dm_req_ready = 1;
    tick();
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    chk("rstw_req_valid", dm_req_valid, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_wb_valid", wb_valid, 0);
    chk("rstw_wb_alu", wb_alu_result, 0);
    chk("rstw_timeout", mem_timeout, 0);
    rst_n = 1;
    dm_rsp_valid = 1; dm_rsp_rdata = 64'hABCD;
    tick();
    chk("rstw_rsp_ignored", wb_valid, 0);
    chk("rstw_stall_after", stall, 0);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register in the LEGv8 pipelined CPU.
- Takes the M-stage and WB-stage fields as they leave EX/MEM, resolves branches, and runs the data-memory access over a valid/ready request and response handshake.
- Stalls upstream stages while an access is outstanding.
- Delivers registered WB-stage values toward MEM/WB.

Parameters:
DATA_W, 64, data and address width
REG_W, 5, register index width
TIMEOUT, 255, max cycles an access may wait in REQ+WAIT_RSP before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  EX/MEM holds a valid instruction
isZeroBranch  in  1  CBZ-type branch
isUnconBranch  in  1  unconditional branch
memRead  in  1  load
memwrite  in  1  store
regwrite  in  1  WB register write enable
mem2reg  in  1  WB selects memory data
shifted_PC  in  DATA_W  branch target
alu_zero  in  1  ALU zero flag
alu_result  in  DATA_W  address / ALU value
write_data_mem  in  DATA_W  store data
write_reg  in  REG_W  destination register
dm_req_valid  out  1  memory request valid
dm_req_ready  in  1  memory accepts request
dm_req_we  out  1  1=store, 0=load
dm_req_addr  out  DATA_W  request address
dm_req_wdata  out  DATA_W  store data
dm_rsp_valid  in  1  load data valid
dm_rsp_rdata  in  DATA_W  load data
stall  out  1  hold IF/ID/EX and EX/MEM
pc_src  out  1  take branch
branch_target  out  DATA_W  next PC when pc_src
flush  out  1  squash younger instructions
wb_valid  out  1  one-cycle pulse, WB fields valid
wb_regwrite  out  1
wb_mem2reg  out  1
wb_read_data  out  DATA_W
wb_alu_result  out  DATA_W
wb_write_reg  out  REG_W
mem_timeout  out  1  sticky access-abort flag

Behaviour:
- Reset:
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs (wb_*, dm_req_*, mem_timeout) go to 0.
  - Reset mid-access drops dm_req_valid immediately and discards the access.
- States:
  - IDLE, REQ, WAIT_RSP.
  - Accept = IDLE and ex_valid; the op is sampled at the accept edge.
- Branch:
  - pc_src = accept & (isUnconBranch | (isZeroBranch & alu_zero)), combinational.
  - flush = pc_src; branch_target = shifted_PC.
  - Branch is evaluated even if a memory flag is also set.
- Non-memory op (accept, memRead=memwrite=0):
  - Load wb_* at the accept edge; wb_valid=1 for the next cycle only.
  - wb_read_data=0; latency 1; stall=0.
- Memory op (accept, memRead|memwrite):
  - stall=1 combinationally in the accept cycle.
  - Latch addr = alu_result, wdata, we = memwrite (memwrite wins if both flags set), plus the WB fields.
  - Go to REQ.
- REQ:
  - dm_req_valid=1; dm_req_* held stable until ready.
  - On ready with a store: complete.
  - On ready with a load: if dm_rsp_valid is also high, complete with rdata; else go to WAIT_RSP.
- WAIT_RSP: dm_req_valid=0; on dm_rsp_valid, capture rdata and complete.
- Complete:
  - Load wb_* on that edge; wb_valid pulses the next cycle; return to IDLE.
- Minimum latencies:
  - Store with ready: wb_valid 2 cycles after accept.
  - Load with same-cycle response: 2 cycles.
- stall:
  - 1 whenever state != IDLE, or in the accept cycle of a memory op.
  - Drops in the cycle after completion.
- Timeout:
  - The counter increments each cycle in REQ/WAIT_RSP and clears on completion or in IDLE.
  - After TIMEOUT cycles without completion, on that edge:
    - return to IDLE;
    - set mem_timeout (sticky until reset);
    - pulse wb_valid with wb_regwrite=0.
- Other edge cases:
  - dm_rsp_valid in IDLE/REQ (without ready) is ignored.
  - ex_valid while state != IDLE is ignored; upstream is stalled.

Decomposition:
- Shared package mem_stage_pkg: state enum (IDLE, REQ, WAIT_RSP) and the DATA_W/REG_W defaults.
- One natural sub-module: mem_timeout_cnt (counter with clear/enable and expiry output).

Test Plan:
- ADD, alu_result=0x10, write_reg=3, regwrite=1 -> next cycle wb_valid=1, wb_alu_result=0x10, wb_write_reg=3, stall never high.
- CBZ, alu_zero=1, shifted_PC=0x40 -> in the accept cycle pc_src=flush=1, branch_target=0x40. Same op with alu_zero=0 -> pc_src=0.
- STUR, addr 0x8, data 0xDEAD, ready low 3 cycles -> dm_req_valid/addr/wdata stable for 4 cycles, stall high throughout, wb_valid 1 cycle after ready.
- LDUR, ready immediate, rsp after 2 cycles with 0x1234, mem2reg=1 -> wb_read_data=0x1234, wb_valid single pulse, stall drops the following cycle.
- TIMEOUT=4, load with ready never high -> after 4 cycles mem_timeout=1, wb_valid pulse with wb_regwrite=0, state IDLE; next ADD completes normally.
- rst_n low during WAIT_RSP -> dm_req_valid, stall and wb_* go to 0 immediately; a later rsp_valid is ignored.
